ula_wb_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the arithmetic ULA.
- Registers each ULA result, its destination register address and its O/C/S/Z flags through a 2-entry valid/ready skid buffer toward the register-file write port.
- Holds the architectural flag register and evaluates branch conditions against it.
- Drops ULA opcodes that are not in the supported arithmetic set and reports them on an error strobe.

---
 rtl/ula_wb_stage.sv | 161 ++++++++++++++++
 tb/tb_ula_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_wb_stage.sv
// ula_wb_stage: execute-to-writeback stage behind the arithmetic ULA.
// Buffers ULA results in a 2-entry valid/ready skid buffer toward the
// register-file write port, holds the architectural {O,C,S,Z} flag register,
// evaluates branch conditions against it and flags unsupported opcodes.
// Optional build macro: STICKY_OVF_EN adds a sticky overflow indicator
// (ports ovf_clr / ovf_sticky).
module ula_wb_stage #(
    parameter int BITS      = 3,
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           op,
    input  logic [BITS-1:0]      resu,
    input  logic                 o_in,
    input  logic                 c_in,
    input  logic                 s_in,
    input  logic                 z_in,
    input  logic                 flag_we,
    input  logic [ADDR_BITS-1:0] dest,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [BITS-1:0]      wb_data,
    output logic [ADDR_BITS-1:0] wb_addr,
    output logic [3:0]           flags_q,
    input  logic [2:0]           cond,
    output logic                 cond_true,
`ifdef STICKY_OVF_EN
    input  logic                 ovf_clr,
    output logic                 ovf_sticky,
`endif
    output logic                 op_err
);

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_S      = 3'b011,
        COND_NS     = 3'b100,
        COND_C      = 3'b101,
        COND_O      = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    // Buffer state: the head entry drives wb_* directly, the skid entry
    // holds the second result while the register file stalls.
    logic [1:0]           count;
    logic [BITS-1:0]      skid_data;
    logic [ADDR_BITS-1:0] skid_addr;

    logic op_supported;
    logic accept;
    logic push;
    logic pop;

    // Opcode filter: only the arithmetic subset is written back.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        op_supported = 1'b0;
        case (op)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: op_supported = 1'b1;
            default:                      op_supported = 1'b0;
        endcase
    end

    // Ready comes from the registered count only, never from wb_ready.
    assign in_ready = (count != 2'd2);
    assign wb_valid = (count != 2'd0);
    assign accept   = in_valid & in_ready;
    assign push     = accept & op_supported;
    assign pop      = wb_valid & wb_ready;

    // Count and head-entry registers; the head keeps its last value when empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            count   <= 2'd0;
            wb_data <= '0;
            wb_addr <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    if (count == 2'd0) begin
                        wb_data <= resu;
                        wb_addr <= dest;
                    end
                end
                2'b01: begin
                    count <= count - 2'd1;
                    if (count == 2'd2) begin
                        wb_data <= skid_data;
                        wb_addr <= skid_addr;
                    end
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry replaces the head.
                    wb_data <= resu;
                    wb_addr <= dest;
                end
                default: ;
            endcase
        end
    end

    // Skid entry capture: loaded when a push lands behind a head that stays.
    always_ff @(posedge clk) begin
        // NOTE: the skid storage has no reset; count gates its use, so its contents never matter until written.
        if (push && !pop && count == 2'd1) begin
            skid_data <= resu;
            skid_addr <= dest;
        end
    end

    // Architectural flags and the unsupported-opcode strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
            op_err  <= 1'b0;
        end else begin
            if (push && flag_we) begin
                flags_q <= {o_in, c_in, s_in, z_in};
            end
            op_err <= accept & ~op_supported;
        end
    end

    // Branch condition decode on the registered flags only.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flags_q[0];
            COND_NZ:     cond_true = ~flags_q[0];
            COND_S:      cond_true = flags_q[1];
            COND_NS:     cond_true = ~flags_q[1];
            COND_C:      cond_true = flags_q[2];
            COND_O:      cond_true = flags_q[3];
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

`ifdef STICKY_OVF_EN
    // Sticky overflow: set by any written-back op reporting overflow; set beats clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (push && o_in) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ula_wb_stage.sv
// Directed testbench for ula_wb_stage: reset, single op, backpressure,
// sustained push/pop, flags/condition decode, unsupported opcodes,
// reset mid-operation and (when built with STICKY_OVF_EN) sticky overflow.
module tb_ula_wb_stage;

    localparam int BITS      = 3;
    localparam int ADDR_BITS = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           op;
    logic [BITS-1:0]      resu;
    logic                 o_in;
    logic                 c_in;
    logic                 s_in;
    logic                 z_in;
    logic                 flag_we;
    logic [ADDR_BITS-1:0] dest;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [BITS-1:0]      wb_data;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [3:0]           flags_q;
    logic [2:0]           cond;
    logic                 cond_true;
    logic                 op_err;
`ifdef STICKY_OVF_EN
    logic                 ovf_clr;
    logic                 ovf_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ula_wb_stage #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .resu      (resu),
        .o_in      (o_in),
        .c_in      (c_in),
        .s_in      (s_in),
        .z_in      (z_in),
        .flag_we   (flag_we),
        .dest      (dest),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .flags_q   (flags_q),
        .cond      (cond),
        .cond_true (cond_true),
`ifdef STICKY_OVF_EN
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky),
`endif
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_data !== 3'd0) begin n_fail++; $display("FAIL reset_wb_data: got %0d want 0", wb_data); end
        n_checks++; if (wb_addr !== 3'd0) begin n_fail++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags_q); end
        n_checks++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL reset_op_err: got %b want 0", op_err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        op = 5'b00000; resu = 3'b011; dest = 3'd5;
        o_in = 1'b0; c_in = 1'b0; s_in = 1'b0; z_in = 1'b0;
        flag_we = 1'b1; wb_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_data !== 3'b011) begin n_fail++; $display("FAIL single_wb_data: got %0d want 3", wb_data); end
        n_checks++; if (wb_addr !== 3'd5) begin n_fail++; $display("FAIL single_wb_addr: got %0d want 5", wb_addr); end
        n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL single_flags: got %b want 0000", flags_q); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", wb_valid); end
        n_checks++; if (wb_data !== 3'b011) begin n_fail++; $display("FAIL single_hold_empty: got %0d want 3", wb_data); end
    endtask

    task automatic test_backpressure();
        flag_we = 1'b0; wb_ready = 1'b0; op = 5'b00001;
        in_valid = 1'b1; resu = 3'd1; dest = 3'd1;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", in_ready); end
        n_checks++; if (wb_data !== 3'd1) begin n_fail++; $display("FAIL bp_head1: got %0d want 1", wb_data); end
        resu = 3'd2; dest = 3'd2;
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
        n_checks++; if (wb_data !== 3'd1) begin n_fail++; $display("FAIL bp_head_stable: got %0d want 1", wb_data); end
        resu = 3'd3; dest = 3'd3;
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_held: got %b want 0", in_ready); end
        n_checks++; if (wb_data !== 3'd1 || wb_addr !== 3'd1) begin n_fail++; $display("FAIL bp_head_held: got %0d/%0d want 1/1", wb_data, wb_addr); end
        wb_ready = 1'b1;
        step();
        n_checks++; if (wb_data !== 3'd2 || wb_addr !== 3'd2) begin n_fail++; $display("FAIL bp_pop2: got %0d/%0d want 2/2", wb_data, wb_addr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_reopen: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (wb_data !== 3'd3 || wb_addr !== 3'd3 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_pop3: got %0d/%0d v=%b want 3/3 v=1", wb_data, wb_addr, wb_valid); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [3];
        seq[0] = 3'd4; seq[1] = 3'd5; seq[2] = 3'd6;
        wb_ready = 1'b1; in_valid = 1'b1; op = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            resu = seq[i]; dest = seq[i];
            step();
            n_checks++; if (wb_data !== seq[i] || wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_data%0d: got %0d v=%b want %0d v=1", i, wb_data, wb_valid, seq[i]); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", wb_valid); end
    endtask

    task automatic test_flags_cond();
        logic [2:0] sel  [8];
        logic       want [8];
        // flags_q = {O,C,S,Z} = 0101 after the C+Z update
        sel[0] = 3'b000; want[0] = 1'b1;
        sel[1] = 3'b001; want[1] = 1'b1;
        sel[2] = 3'b010; want[2] = 1'b0;
        sel[3] = 3'b011; want[3] = 1'b0;
        sel[4] = 3'b100; want[4] = 1'b1;
        sel[5] = 3'b101; want[5] = 1'b1;
        sel[6] = 3'b110; want[6] = 1'b0;
        sel[7] = 3'b111; want[7] = 1'b0;
        cond = 3'b001; wb_ready = 1'b1;
        op = 5'b00101; resu = 3'd2; dest = 3'd4;
        o_in = 1'b0; c_in = 1'b1; s_in = 1'b0; z_in = 1'b1;
        flag_we = 1'b1; in_valid = 1'b1;
        #1;
        n_checks++; if (cond_true !== 1'b0) begin n_fail++; $display("FAIL cond_accept_cycle: got %b want 0", cond_true); end
        step();
        in_valid = 1'b0;
        n_checks++; if (flags_q !== 4'b0101) begin n_fail++; $display("FAIL flags_update: got %b want 0101", flags_q); end
        n_checks++; if (cond_true !== 1'b1) begin n_fail++; $display("FAIL cond_after_update: got %b want 1", cond_true); end
        for (int i = 0; i < 8; i++) begin
            cond = sel[i];
            #1;
            n_checks++; if (cond_true !== want[i]) begin n_fail++; $display("FAIL cond_sel%0d: got %b want %b", i, cond_true, want[i]); end
        end
        flag_we = 1'b0; c_in = 1'b0; z_in = 1'b0; s_in = 1'b1;
        op = 5'b00000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (flags_q !== 4'b0101) begin n_fail++; $display("FAIL flags_no_we: got %b want 0101", flags_q); end
        step();
    endtask

    task automatic test_unsupported();
        op = 5'b00010; resu = 3'd7; dest = 3'd7;
        o_in = 1'b1; c_in = 1'b0; s_in = 1'b1; z_in = 1'b0;
        flag_we = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; flag_we = 1'b0;
        n_checks++; if (op_err !== 1'b1) begin n_fail++; $display("FAIL unsup_op_err: got %b want 1", op_err); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_no_push: got %b want 0", wb_valid); end
        n_checks++; if (flags_q !== 4'b0101) begin n_fail++; $display("FAIL unsup_flags: got %b want 0101", flags_q); end
        step();
        n_checks++; if (op_err !== 1'b0) begin n_fail++; $display("FAIL unsup_strobe_len: got %b want 0", op_err); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_still_empty: got %b want 0", wb_valid); end
    endtask

`ifdef STICKY_OVF_EN
    task automatic test_sticky_ovf();
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_initial: got %b want 0", ovf_sticky); end
        wb_ready = 1'b1; flag_we = 1'b0; ovf_clr = 1'b0;
        op = 5'b00100; resu = 3'd1; dest = 3'd1; o_in = 1'b1; in_valid = 1'b1;
        step();
        n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set: got %b want 1", ovf_sticky); end
        ovf_clr = 1'b1;
        step();
        n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_set_wins: got %b want 1", ovf_sticky); end
        in_valid = 1'b0;
        step();
        n_checks++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear: got %b want 0", ovf_sticky); end
        ovf_clr = 1'b0; o_in = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid();
        wb_ready = 1'b0; op = 5'b00000; flag_we = 1'b1;
        o_in = 1'b0; c_in = 1'b1; s_in = 1'b1; z_in = 1'b0;
        in_valid = 1'b1; resu = 3'd5; dest = 3'd2;
        step();
        resu = 3'd6;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", in_ready); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; wb_ready = 1'b1;
        n_checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_discard: got v=%b r=%b want v=0 r=1", wb_valid, in_ready); end
        n_checks++; if (flags_q !== 4'b0000 || wb_data !== 3'd0) begin n_fail++; $display("FAIL mid_state: got f=%b d=%0d want 0000/0", flags_q, wb_data); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_nothing_written: got %b want 0", wb_valid); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; resu = '0;
        o_in = 1'b0; c_in = 1'b0; s_in = 1'b0; z_in = 1'b0;
        flag_we = 1'b0; dest = '0; wb_ready = 1'b0; cond = '0;
`ifdef STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        test_reset();
        test_single_op();
        test_backpressure();
        test_back_to_back();
        test_flags_cond();
        test_unsupported();
`ifdef STICKY_OVF_EN
        test_sticky_ovf();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
